// File: rtl/ctrl_unit_pipe.sv
// rtl/ctrl_unit_pipe.sv - ID-stage control unit with stall/flush/halt sequencing and WB control pipe
module ctrl_unit_pipe #(
   parameter int IW        = 16,
   parameter int WB_DEPTH  = 3,
   parameter int STALL_CYC = 1,
   parameter int FLUSH_CYC = 2
) (
   input  logic          CLOCK,
   input  logic          in_rst,
   input  logic [IW-1:0] in_buf,
   input  logic          in_valid,
   input  logic          in_hz,
   input  logic          in_br_taken,
   output logic [IW-1:0] out_ex,
   output logic          out_ex_valid,
   output logic [1:0]    out_reg_write,
   output logic [3:0]    out_alu_op,
   output logic          out_mem_rd,
   output logic          out_mem_wr,
   output logic          out_and,
   output logic          out_pc_src,
   output logic          out_stall,
   output logic          out_halt,
   output logic [1:0]    out_wb_reg_write,
   output logic          out_wb_valid
);

   localparam logic [3:0] OP_RALU = 4'b0000;
   localparam logic [3:0] OP_LW   = 4'b0100;
   localparam logic [3:0] OP_SW   = 4'b0101;
   localparam logic [3:0] OP_ADDI = 4'b0110;
   localparam logic [3:0] OP_BNE  = 4'b1000;
   localparam logic [3:0] OP_BEQ  = 4'b1100;
   localparam logic [3:0] OP_HALT = 4'b1110;

   localparam logic [3:0] STALL_LOAD = 4'(STALL_CYC - 1);
   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYC - 1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STALL = 2'd1,
      S_FLUSH = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   logic [3:0] opcode;
   logic [3:0] funct;

   assign opcode = in_buf[IW-1:IW-4];
   assign funct  = in_buf[3:0];

   // Decoded control word for the instruction currently in IF/ID
   logic       dec_ok;
   logic [1:0] dec_rw;
   logic [3:0] dec_alu;
   logic       dec_rd;
   logic       dec_wr;
   logic       dec_and;

   // Opcode decode; unknown opcodes (and HALT, handled by the sequencer) yield no control word
   always_comb begin
      dec_ok  = 1'b0;
      dec_rw  = 2'b00;
      dec_alu = 4'b0000;
      dec_rd  = 1'b0;
      dec_wr  = 1'b0;
      dec_and = 1'b0;
      case (opcode)
         OP_RALU: begin
            dec_ok  = 1'b1;
            dec_rw  = (funct == 4'b0100 || funct == 4'b0101) ? 2'b10 : 2'b01;
            dec_alu = funct;
         end
         OP_LW: begin
            dec_ok = 1'b1;
            dec_rw = 2'b01;
            dec_rd = 1'b1;
         end
         OP_SW: begin
            dec_ok = 1'b1;
            dec_wr = 1'b1;
         end
         OP_ADDI: begin
            dec_ok = 1'b1;
            dec_rw = 2'b01;
         end
         OP_BEQ, OP_BNE: begin
            dec_ok  = 1'b1;
            dec_and = 1'b1;
            dec_alu = 4'b0001;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [IW-1:0] ex_q, ex_d;
   logic          ex_valid_q, ex_valid_d;
   logic [1:0]    reg_write_q, reg_write_d;
   logic [3:0]    alu_op_q, alu_op_d;
   logic          mem_rd_q, mem_rd_d;
   logic          mem_wr_q, mem_wr_d;
   logic          and_q, and_d;
   logic          pc_src_q, pc_src_d;
   logic          stall_q, stall_d;
   logic          halt_q, halt_d;

   // Sequencer next state: every output defaults to a bubble, branch beats hazard beats HALT
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ex_d        = '0;
      ex_valid_d  = 1'b0;
      reg_write_d = 2'b00;
      alu_op_d    = 4'b0000;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      and_d       = 1'b0;
      pc_src_d    = 1'b0;
      stall_d     = 1'b0;
      halt_d      = 1'b0;

      if (state_q == S_HALT) begin
         // Only an older branch resolving in EX can pull the pipe out of HALT
         if (in_br_taken) begin
            state_d  = S_FLUSH;
            cnt_d    = FLUSH_LOAD;
            pc_src_d = 1'b1;
         end else begin
            stall_d = 1'b1;
            halt_d  = 1'b1;
         end
      end else if (state_q == S_STALL && cnt_q != 4'd0) begin
         if (in_br_taken) begin
            state_d  = S_FLUSH;
            cnt_d    = FLUSH_LOAD;
            pc_src_d = 1'b1;
         end else begin
            stall_d = 1'b1;
            cnt_d   = cnt_q - 4'd1;
         end
      end else if (state_q == S_FLUSH && cnt_q != 4'd0) begin
         // IF is refetching the target: no stall, hazards are meaningless here
         cnt_d = cnt_q - 4'd1;
      end else begin
         // RUN, or the last bubble of STALL/FLUSH: this edge already issues
         if (in_br_taken) begin
            state_d  = S_FLUSH;
            cnt_d    = FLUSH_LOAD;
            pc_src_d = 1'b1;
         end else if (in_hz) begin
            state_d = S_STALL;
            cnt_d   = STALL_LOAD;
            stall_d = 1'b1;
         end else if (in_valid && opcode == OP_HALT) begin
            state_d = S_HALT;
            cnt_d   = 4'd0;
            stall_d = 1'b1;
            halt_d  = 1'b1;
         end else begin
            state_d = S_RUN;
            cnt_d   = 4'd0;
            if (in_valid && dec_ok) begin
               ex_d        = in_buf;
               ex_valid_d  = 1'b1;
               reg_write_d = dec_rw;
               alu_op_d    = dec_alu;
               mem_rd_d    = dec_rd;
               mem_wr_d    = dec_wr;
               and_d       = dec_and;
            end
         end
      end
   end

   // State, counter and the registered ID/EX control word
   always_ff @(posedge CLOCK or negedge in_rst) begin
      if (!in_rst) begin
         state_q     <= S_RUN;
         cnt_q       <= 4'd0;
         ex_q        <= '0;
         ex_valid_q  <= 1'b0;
         reg_write_q <= 2'b00;
         alu_op_q    <= 4'b0000;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         and_q       <= 1'b0;
         pc_src_q    <= 1'b0;
         stall_q     <= 1'b0;
         halt_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ex_q        <= ex_d;
         ex_valid_q  <= ex_valid_d;
         reg_write_q <= reg_write_d;
         alu_op_q    <= alu_op_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         and_q       <= and_d;
         pc_src_q    <= pc_src_d;
         stall_q     <= stall_d;
         halt_q      <= halt_d;
      end
   end

   logic [2:0] wb_q [WB_DEPTH];

   // Write-back control shift pipe; free-running so bubbles flow through as zeros
   always_ff @(posedge CLOCK or negedge in_rst) begin
      if (!in_rst) begin
         for (int i = 0; i < WB_DEPTH; i++) begin
            wb_q[i] <= 3'b000;
         end
      end else begin
         wb_q[0] <= {reg_write_q, ex_valid_q};
         for (int i = 1; i < WB_DEPTH; i++) begin
            wb_q[i] <= wb_q[i-1];
         end
      end
   end

   assign out_ex           = ex_q;
   assign out_ex_valid     = ex_valid_q;
   assign out_reg_write    = reg_write_q;
   assign out_alu_op       = alu_op_q;
   assign out_mem_rd       = mem_rd_q;
   assign out_mem_wr       = mem_wr_q;
   assign out_and          = and_q;
   assign out_pc_src       = pc_src_q;
   assign out_stall        = stall_q;
   assign out_halt         = halt_q;
   assign out_wb_reg_write = wb_q[WB_DEPTH-1][2:1];
   assign out_wb_valid     = wb_q[WB_DEPTH-1][0];

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// tb/tb_ctrl_unit_pipe.sv - directed table-driven bench for ctrl_unit_pipe
module tb_ctrl_unit_pipe;

   localparam int WB = 3;

   logic        CLOCK = 1'b0;
   logic        in_rst;
   logic [15:0] in_buf;
   logic        in_valid, in_hz, in_br_taken;
   logic [15:0] out_ex;
   logic        out_ex_valid;
   logic [1:0]  out_reg_write;
   logic [3:0]  out_alu_op;
   logic        out_mem_rd, out_mem_wr, out_and, out_pc_src, out_stall, out_halt;
   logic [1:0]  out_wb_reg_write;
   logic        out_wb_valid;

   int checks = 0;
   int errors = 0;

   logic [2:0] hist [WB+1];

   typedef struct {
      string       name;
      logic [15:0] ibuf;
      logic        v;
      logic        hz;
      logic        br;
      logic [28:0] exp;
   } vec_t;

   vec_t tbl [10];

   ctrl_unit_pipe #(.IW(16), .WB_DEPTH(WB), .STALL_CYC(2), .FLUSH_CYC(2)) dut (
      .CLOCK(CLOCK), .in_rst(in_rst), .in_buf(in_buf), .in_valid(in_valid),
      .in_hz(in_hz), .in_br_taken(in_br_taken), .out_ex(out_ex),
      .out_ex_valid(out_ex_valid), .out_reg_write(out_reg_write),
      .out_alu_op(out_alu_op), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_and(out_and), .out_pc_src(out_pc_src), .out_stall(out_stall),
      .out_halt(out_halt), .out_wb_reg_write(out_wb_reg_write), .out_wb_valid(out_wb_valid)
   );

   always #5 CLOCK = ~CLOCK;

   function automatic logic [28:0] outv(input logic [15:0] ex, input logic exv,
                                        input logic [1:0] rw, input logic [3:0] alu,
                                        input logic rd, input logic wr, input logic an,
                                        input logic pc, input logic st, input logic ht);
      return {ex, exv, rw, alu, rd, wr, an, pc, st, ht};
   endfunction

   function automatic logic [31:0] dut_out();
      return {out_ex, out_ex_valid, out_reg_write, out_alu_op, out_mem_rd, out_mem_wr,
              out_and, out_pc_src, out_stall, out_halt, out_wb_reg_write, out_wb_valid};
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
      end
   endtask

   task automatic clear_hist();
      for (int i = 0; i <= WB; i++) hist[i] = 3'b000;
   endtask

   // Drive one cycle at the falling edge, let one rising edge pass, then compare
   task automatic step(input string nm, input logic [15:0] b, input logic v,
                       input logic hz, input logic br, input logic [28:0] e);
      in_buf = b; in_valid = v; in_hz = hz; in_br_taken = br;
      @(posedge CLOCK);
      @(negedge CLOCK);
      for (int i = WB; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {e[11:10], e[12]};
      check(nm, dut_out(), {e, hist[WB]});
   endtask

   logic [28:0] bub, stb, flb, hlt;

   initial begin
      bub = outv(16'h0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 0, 0);
      stb = outv(16'h0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 1, 0);
      flb = outv(16'h0, 0, 2'b00, 4'h0, 0, 0, 0, 1, 0, 0);
      hlt = outv(16'h0, 0, 2'b00, 4'h0, 0, 0, 0, 0, 1, 1);

      tbl[0] = '{"ralu_add",  16'h0121, 1, 0, 0, outv(16'h0121, 1, 2'b01, 4'h1, 0, 0, 0, 0, 0, 0)};
      tbl[1] = '{"ralu_mul",  16'h0044, 1, 0, 0, outv(16'h0044, 1, 2'b10, 4'h4, 0, 0, 0, 0, 0, 0)};
      tbl[2] = '{"lw",        16'h4740, 1, 0, 0, outv(16'h4740, 1, 2'b01, 4'h0, 1, 0, 0, 0, 0, 0)};
      tbl[3] = '{"sw",        16'h5123, 1, 0, 0, outv(16'h5123, 1, 2'b00, 4'h0, 0, 1, 0, 0, 0, 0)};
      tbl[4] = '{"addi",      16'h6abc, 1, 0, 0, outv(16'h6abc, 1, 2'b01, 4'h0, 0, 0, 0, 0, 0, 0)};
      tbl[5] = '{"beq",       16'hC892, 1, 0, 0, outv(16'hC892, 1, 2'b00, 4'h1, 0, 0, 1, 0, 0, 0)};
      tbl[6] = '{"bne",       16'h8001, 1, 0, 0, outv(16'h8001, 1, 2'b00, 4'h1, 0, 0, 1, 0, 0, 0)};
      tbl[7] = '{"op1111",    16'hF123, 1, 0, 0, bub};
      tbl[8] = '{"invalid",   16'h0121, 0, 0, 0, bub};
      tbl[9] = '{"ralu_div",  16'h0005, 1, 0, 0, outv(16'h0005, 1, 2'b10, 4'h5, 0, 0, 0, 0, 0, 0)};

      in_rst = 1'b0; in_buf = '0; in_valid = 0; in_hz = 0; in_br_taken = 0;
      clear_hist();
      repeat (2) @(negedge CLOCK);
      in_rst = 1'b1;
      check("reset_state", dut_out(), 32'h0);

      for (int i = 0; i < 10; i++) begin
         step(tbl[i].name, tbl[i].ibuf, tbl[i].v, tbl[i].hz, tbl[i].br, tbl[i].exp);
      end

      // load-use stall, two bubbles, then the held instruction issues
      step("stall_lw",    16'h4740, 1, 0, 0, outv(16'h4740, 1, 2'b01, 4'h0, 1, 0, 0, 0, 0, 0));
      step("stall_b1",    16'h0121, 1, 1, 0, stb);
      step("stall_b2",    16'h0121, 1, 0, 0, stb);
      step("stall_issue", 16'h0121, 1, 0, 0, outv(16'h0121, 1, 2'b01, 4'h1, 0, 0, 0, 0, 0, 0));

      // taken branch: pc_src one cycle, two flush bubbles without stall
      step("br_beq",      16'hC892, 1, 0, 0, outv(16'hC892, 1, 2'b00, 4'h1, 0, 0, 1, 0, 0, 0));
      step("br_flush1",   16'h0121, 1, 0, 1, flb);
      step("br_flush2",   16'h0121, 1, 0, 0, bub);
      step("br_issue",    16'h0121, 1, 0, 0, outv(16'h0121, 1, 2'b01, 4'h1, 0, 0, 0, 0, 0, 0));

      // hazard and branch together: branch wins, hazard ignored inside flush
      step("hzbr_flush",  16'h0121, 1, 1, 1, flb);
      step("hzbr_ignore", 16'h0121, 1, 1, 0, bub);
      step("hzbr_issue",  16'h6abc, 1, 0, 0, outv(16'h6abc, 1, 2'b01, 4'h0, 0, 0, 0, 0, 0, 0));

      // branch overrides an ongoing stall
      step("ovr_stall",   16'h0121, 1, 1, 0, stb);
      step("ovr_flush",   16'h0121, 1, 0, 1, flb);
      step("ovr_bub",     16'h0121, 1, 0, 0, bub);
      step("ovr_issue",   16'h5123, 1, 0, 0, outv(16'h5123, 1, 2'b00, 4'h0, 0, 1, 0, 0, 0, 0));

      // HALT holds for 20 cycles, then an older taken branch releases it
      step("halt_enter",  16'hEFFF, 1, 0, 0, hlt);
      for (int i = 0; i < 20; i++) step("halt_hold", 16'h0121, 1, 1, 0, hlt);
      step("halt_br",     16'h0121, 1, 0, 1, flb);
      step("halt_flush",  16'h0121, 1, 0, 0, bub);
      step("halt_issue",  16'h0121, 1, 0, 0, outv(16'h0121, 1, 2'b01, 4'h1, 0, 0, 0, 0, 0, 0));

      // asynchronous reset in the middle of HALT
      step("halt2_enter", 16'hEFFF, 1, 0, 0, hlt);
      step("halt2_hold",  16'h0121, 1, 0, 0, hlt);
      #2 in_rst = 1'b0;
      #1 check("async_reset", dut_out(), 32'h0);
      @(negedge CLOCK);
      clear_hist();
      check("reset_held", dut_out(), 32'h0);
      in_rst = 1'b1;
      step("post_reset",  16'h0121, 1, 0, 0, outv(16'h0121, 1, 2'b01, 4'h1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < WB; i++) step("post_drain", 16'h0121, 0, 0, 0, bub);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
